// File: rtl/vram_arbiter_if.sv
// Bus bundle between CPU decode, video fetcher, the VRAM arbiter and the RAM macro.
interface vram_arbiter_if #(
  parameter int unsigned AW = 13
) ();

  localparam int unsigned DW = 8;

  // CPU side
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  // Video fetch side
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;

  // RAM side
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  vid_req, vid_addr,
    output vid_ack, vid_rdata,
    output ram_cs, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  // Requesters and RAM view
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output vid_req, vid_addr,
    input  vid_ack, vid_rdata,
    input  ram_cs, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/vram_arbiter.sv
// Shares one single-port 8-bit VRAM between the CPU bus and the video fetcher.
// Video has fixed priority; a starvation counter forces a CPU grant after
// STARVE_LIM consecutive video wins while the CPU is waiting.
module vram_arbiter #(
  parameter int unsigned AW         = 13,
  parameter int unsigned STARVE_LIM = 2
) (
  input  logic           clk,
  input  logic           reset,
  vram_arbiter_if.slave  bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LIM_C = CW'(STARVE_LIM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_CAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  state_e        state_q,     state_d;
  owner_e        owner_q,     owner_d;
  logic          wr_q,        wr_d;
  logic [CW-1:0] starve_q,    starve_d;
  logic          cpu_ack_q,   cpu_ack_d;
  logic          vid_ack_q,   vid_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] vid_rdata_q, vid_rdata_d;
  logic          ram_cs_q,    ram_cs_d;
  logic          ram_we_q,    ram_we_d;
  logic [AW-1:0] ram_addr_q,  ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  logic          cpu_forced_c;

  // CPU must win this grant because video has won STARVE_LIM times in a row
  assign cpu_forced_c = bus.cpu_req && (starve_q == STARVE_LIM_C);

  // Next-state and output computation for the access sequencer
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    starve_d    = starve_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.vid_req && !cpu_forced_c) begin
          owner_d    = OWN_VID;
          wr_d       = 1'b0;
          state_d    = S_ACC;
          ram_cs_d   = 1'b1;
          ram_addr_d = bus.vid_addr;
          if (bus.cpu_req && (starve_q < STARVE_LIM_C)) begin
            starve_d = starve_q + CW'(1);
          end
        end else if (bus.cpu_req) begin
          owner_d     = OWN_CPU;
          wr_d        = bus.cpu_we;
          state_d     = S_ACC;
          ram_cs_d    = 1'b1;
          ram_we_d    = bus.cpu_we;
          ram_addr_d  = bus.cpu_addr;
          ram_wdata_d = bus.cpu_wdata;
          starve_d    = '0;
        end
      end
      // RAM samples the command at the end of this cycle
      S_ACC: begin
        state_d = S_CAP;
      end
      // Read data is valid now; capture it and strobe the owner's ack
      S_CAP: begin
        state_d = S_DONE;
        if (owner_q == OWN_CPU) begin
          cpu_ack_d = 1'b1;
          if (!wr_q) begin
            cpu_rdata_d = bus.ram_rdata;
          end
        end else begin
          vid_ack_d   = 1'b1;
          vid_rdata_d = bus.ram_rdata;
        end
      end
      // Ack is high for this cycle; requester drops req before IDLE samples
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_VID;
      wr_q        <= 1'b0;
      starve_q    <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      starve_q    <= starve_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes expected acks,
// a negedge monitor pops and compares whenever an ack is presented.
module tb_vram_arbiter;

  localparam int unsigned AW    = 13;
  localparam int unsigned LIM   = 2;
  localparam int          WAITN = 200;

  typedef struct {
    logic       is_cpu;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset;

  vram_arbiter_if #(.AW(AW)) bus ();

  vram_arbiter #(.AW(AW), .STARVE_LIM(LIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference single-port RAM: read data valid the cycle after the cs edge
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   cs_cnt = 0, we_cnt = 0, cpu_ack_cnt = 0, vid_ack_cnt = 0;
  int   cpu_ack_cyc = 0, vid_ack_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts RAM/ack activity and scores each ack against the queue
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (bus.ram_cs) cs_cnt++;
    if (bus.ram_we) we_cnt++;
    if (bus.cpu_ack) begin cpu_ack_cnt++; cpu_ack_cyc = cyc; end
    if (bus.vid_ack) begin vid_ack_cnt++; vid_ack_cyc = cyc; end
    if (reset && (bus.cpu_ack || bus.vid_ack)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'd0, bus.cpu_ack, bus.vid_ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("ack_owner", {30'd0, bus.cpu_ack, bus.vid_ack}, e.is_cpu ? 32'd2 : 32'd1);
        if (e.is_cpu) check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e.data));
        else          check("vid_rdata", 32'(bus.vid_rdata), 32'(e.data));
      end
    end
  end

  function automatic exp_t mk(input logic is_cpu, input logic [7:0] d);
    exp_t e;
    e.is_cpu = is_cpu;
    e.data   = d;
    return e;
  endfunction

  // Called just after a posedge; returns negedges waited until cpu_ack
  task automatic cpu_go(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                        output int n);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!bus.cpu_ack && n < WAITN) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAITN) check("cpu_ack_timeout", 32'(n), 32'd0);
    @(posedge clk); #2;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic vid_go(input logic [AW-1:0] a);
    int n;
    bus.vid_req  = 1'b1;
    bus.vid_addr = a;
    n = 0;
    @(negedge clk);
    while (!bus.vid_ack && n < WAITN) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAITN) check("vid_ack_timeout", 32'(n), 32'd0);
    @(posedge clk); #2;
    bus.vid_req = 1'b0;
  endtask

  initial begin
    int n, cs0, we0, vid0, ack0, acks;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0; bus.ram_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
    mem[13'h0123] = 8'hA5;
    mem[13'h0040] = 8'h11;
    mem[13'h0041] = 8'h22;
    mem[13'h0050] = 8'h77;
    mem[13'h0051] = 8'h88;
    mem[13'h0060] = 8'h5D;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_acks",  {30'd0, bus.cpu_ack, bus.vid_ack}, 32'd0);
    check("rst_ram_cs_we", {30'd0, bus.ram_cs, bus.ram_we}, 32'd0);
    check("rst_ram_addr",  32'(bus.ram_addr), 32'd0);
    check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    check("rst_rdatas", {16'd0, bus.cpu_rdata, bus.vid_rdata}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;

    // Plain CPU read: one cs cycle, ack during E3..E4
    cs0 = cs_cnt; ack0 = cpu_ack_cnt;
    exp_q.push_back(mk(1'b1, 8'hA5));
    cpu_go(1'b0, 13'h0123, 8'h00, n);
    check("t1_latency", 32'(n), 32'd3);
    check("t1_cs_cycles", 32'(cs_cnt - cs0), 32'd1);
    check("t1_ack_cycles", 32'(cpu_ack_cnt - ack0), 32'd1);

    // Write to top address then read back; write leaves cpu_rdata alone
    vid0 = vid_ack_cnt; we0 = we_cnt;
    exp_q.push_back(mk(1'b1, 8'hA5));
    cpu_go(1'b1, 13'h1FFF, 8'h3C, n);
    check("t2_we_cycles", 32'(we_cnt - we0), 32'd1);
    exp_q.push_back(mk(1'b1, 8'h3C));
    cpu_go(1'b0, 13'h1FFF, 8'h00, n);
    check("t2_no_vid_ack", 32'(vid_ack_cnt - vid0), 32'd0);

    // Simultaneous requests: video first, CPU ack 4 cycles later
    exp_q.push_back(mk(1'b0, 8'h11));
    exp_q.push_back(mk(1'b1, 8'h22));
    fork
      vid_go(13'h0040);
      cpu_go(1'b0, 13'h0041, 8'h00, n);
    join
    check("t3_ack_spacing", 32'(cpu_ack_cyc - vid_ack_cyc), 32'd4);

    // Both held: V,V,C,V,V,C grant pattern
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(mk(1'b0, 8'h77));
      exp_q.push_back(mk(1'b0, 8'h77));
      exp_q.push_back(mk(1'b1, 8'h88));
    end
    bus.vid_req = 1'b1; bus.vid_addr = 13'h0050;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0051;
    acks = 0; n = 0;
    while (acks < 6 && n < WAITN) begin
      @(negedge clk);
      n++;
      if (bus.cpu_ack || bus.vid_ack) acks++;
    end
    check("t4_six_acks", 32'(acks), 32'd6);
    @(posedge clk); #2;
    bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset during ACC: no ack, cs drops on the next cycle
    @(posedge clk); #2;
    ack0 = cpu_ack_cnt + vid_ack_cnt;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0060;
    @(posedge clk); #2;
    check("t5_cs_in_acc", 32'(bus.ram_cs), 32'd1);
    reset = 1'b0; bus.cpu_req = 1'b0;
    @(posedge clk); #2;
    check("t5_cs_after_rst", 32'(bus.ram_cs), 32'd0);
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    check("t5_no_ack", 32'(cpu_ack_cnt + vid_ack_cnt - ack0), 32'd0);
    exp_q.push_back(mk(1'b1, 8'h5D));
    cpu_go(1'b0, 13'h0060, 8'h00, n);
    check("t5_latency", 32'(n), 32'd3);

    // Back-to-back CPU writes then reads, including address 0
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b1, 8'h5D));
      cpu_go(1'b1, AW'(i * 1000), 8'(8'hC0 + i), n);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(1'b1, 8'(8'hC0 + i)));
      cpu_go(1'b0, AW'(i * 1000), 8'h00, n);
    end
    repeat (3) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
